// File: rtl/registered_scan_mux_if.sv
// Bus bundle for registered_scan_mux: the request/select side and the
// registered output side. clk and rst_n stay plain module ports.
interface registered_scan_mux_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
);
    logic [WIDTH*CHANNELS-1:0] in_data;
    logic [SEL_W-1:0]          sel;
    logic                      mode;
    logic                      req;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_ch;
    logic                      out_valid;
    logic [7:0]                drop_cnt;

    // Producer/consumer side: drives requests, observes the held sample.
    modport master (
        output in_data, sel, mode, req, out_ready,
        input  out_data, out_ch, out_valid, drop_cnt
    );

    // Mux side.
    modport slave (
        input  in_data, sel, mode, req, out_ready,
        output out_data, out_ch, out_valid, drop_cnt
    );
endinterface

// File: rtl/registered_scan_mux.sv
// registered_scan_mux: picks one of CHANNELS input channels on request and
// holds it in a one-deep output register with a valid/ready handshake.
// Requests arriving while the held sample is stalled are dropped and counted
// in a saturating 8-bit counter.
// Optional feature macro: REGISTERED_SCAN_MUX_SCAN_EN enables scan mode
// (mode=1 walks a round-robin channel pointer). Without it the mode input is
// ignored and every capture uses sel.
module registered_scan_mux #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    registered_scan_mux_if.slave bus
);

    // Output holding register and drop counter.
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q,   out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    // Unpacked view of the flat channel bus.
    logic [WIDTH-1:0] chan [CHANNELS];

    genvar gi;
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
        assign chan[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end

    // A request is taken when the holding register is empty or being
    // emptied this same cycle; otherwise it is dropped.
    logic capture;
    logic drop;
    assign capture = bus.req && (!out_valid_q || bus.out_ready);
    assign drop    = bus.req &&  out_valid_q && !bus.out_ready;

    // Channel chosen for this cycle's capture.
    logic [SEL_W-1:0] pick;

`ifdef REGISTERED_SCAN_MUX_SCAN_EN
    logic [SEL_W-1:0] ptr_q, ptr_d;

    assign pick = bus.mode ? ptr_q : bus.sel;

    // Advance the scan pointer only on a scan-mode capture; CHANNELS is a
    // power of two so the SEL_W-bit increment wraps CHANNELS-1 to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (capture && bus.mode) begin
            ptr_d = ptr_q + SEL_W'(1);
        end
    end

    // Scan pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Mode is kept on the bus for pin compatibility but has no function.
    logic mode_unused;
    assign mode_unused = bus.mode;
    assign pick        = bus.sel;
`endif

    // Next state of the holding register: load on capture, else a pop clears
    // valid while data/channel hold their last values.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (capture) begin
            out_data_d  = chan[pick];
            out_ch_d    = pick;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Saturating count of dropped requests.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Output and counter registers; reset wins over capture and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_registered_scan_mux.sv
// Self-checking bench for registered_scan_mux (WIDTH=4, CHANNELS=8).
// A behavioural model tracks the expected outputs every cycle; directed steps
// also check hand-computed literal values. Follows the
// REGISTERED_SCAN_MUX_SCAN_EN macro the same way the design does.
module tb_registered_scan_mux;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 8;
    localparam int SEL_W    = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    registered_scan_mux_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) bus ();

    registered_scan_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    bit checking = 1'b0;
    bit quiet    = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit scan_en;
    int m_valid, m_data, m_ch, m_ptr, m_drop;

    initial begin
`ifdef REGISTERED_SCAN_MUX_SCAN_EN
        scan_en = 1'b1;
`else
        scan_en = 1'b0;
`endif
    end

    function automatic int chan_val(input logic [WIDTH*CHANNELS-1:0] d, input int k);
        return int'(d[k*WIDTH +: WIDTH]);
    endfunction

    function automatic int pick_of(input bit m, input int s, input int p);
        return (scan_en && m) ? p : s;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 0; m_data <= 0; m_ch <= 0; m_ptr <= 0; m_drop <= 0;
        end else if (bus.req && (m_valid == 0 || bus.out_ready)) begin
            m_valid <= 1;
            m_ch    <= pick_of(bus.mode, int'(bus.sel), m_ptr);
            m_data  <= chan_val(bus.in_data, pick_of(bus.mode, int'(bus.sel), m_ptr));
            if (scan_en && bus.mode) m_ptr <= (m_ptr + 1) % CHANNELS;
        end else begin
            if (bus.out_ready) m_valid <= 0;
            if (bus.req && m_valid == 1 && !bus.out_ready)
                m_drop <= (m_drop + 1 > 255) ? 255 : m_drop + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            check("cyc_valid", int'(bus.out_valid), m_valid);
            check("cyc_ch",    int'(bus.out_ch),    m_ch);
            check("cyc_data",  int'(bus.out_data),  m_data);
            check("cyc_drop",  int'(bus.drop_cnt),  m_drop);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load_default_data();
        for (int k = 0; k < CHANNELS; k++) bus.in_data[k*WIDTH +: WIDTH] = WIDTH'(k + 1);
    endtask

    task automatic drive(input bit r, input bit m, input int s, input bit rdy);
        bus.req = r; bus.mode = m; bus.sel = SEL_W'(s); bus.out_ready = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (!quiet)
            $display("t=%0t rst_n=%b req=%b mode=%b sel=%0d rdy=%b -> valid=%b ch=%0d data=%0d drop=%0d",
                     $time, rst_n, bus.req, bus.mode, bus.sel, bus.out_ready,
                     bus.out_valid, bus.out_ch, bus.out_data, bus.drop_cnt);
    endtask

    task automatic expect_out(input string name, input int v, input int ch, input int d);
        check({name, "_valid"}, int'(bus.out_valid), v);
        check({name, "_ch"},    int'(bus.out_ch),    ch);
        check({name, "_data"},  int'(bus.out_data),  d);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        load_default_data();
        drive(1'b1, 1'b0, 3, 1'b1);   // capture request under reset must be ignored
        rst_n = 1'b0;
        tick();
        checking = 1'b1;
        tick();
        rst_n = 1'b1;
        expect_out("reset", 0, 0, 0);
        check("reset_drop", int'(bus.drop_cnt), 0);

        // Direct capture of channel 5, then pop.
        drive(1'b1, 1'b0, 5, 1'b1);
        tick();
        expect_out("direct", 1, 5, 6);
        drive(1'b0, 1'b0, 5, 1'b1);
        tick();
        expect_out("direct_pop", 0, 5, 6);

`ifdef REGISTERED_SCAN_MUX_SCAN_EN
        // Scan wrap with continuous pop+capture.
        drive(1'b1, 1'b1, 0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out($sformatf("scan%0d", i), 1, i % 8, (i % 8) + 1);
        end
        // Stall with 3 dropped requests while inputs churn.
        drive(1'b1, 1'b1, 6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.in_data = ~bus.in_data;
            bus.sel     = SEL_W'(i);
            bus.mode    = i[0];
            tick();
        end
        load_default_data();
        expect_out("stall", 1, 1, 2);
        check("stall_drop", int'(bus.drop_cnt), 3);
        // Release: scan resumes at channel 2.
        drive(1'b1, 1'b1, 0, 1'b1);
        tick();
        expect_out("resume", 1, 2, 3);
        // Direct capture in between must not disturb the pointer.
        drive(1'b1, 1'b0, 6, 1'b1);
        tick();
        expect_out("direct_mid", 1, 6, 7);
        drive(1'b1, 1'b1, 0, 1'b1);
        tick();
        expect_out("scan_after_direct", 1, 3, 4);
        // Stall with ptr=4, then reset mid-stall.
        drive(1'b1, 1'b1, 0, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_out("rst_mid", 0, 0, 0);
        check("rst_mid_drop", int'(bus.drop_cnt), 0);
        drive(1'b1, 1'b1, 5, 1'b1);
        tick();
        expect_out("scan_post_rst", 1, 0, 1);
`else
        // Mode input ignored: always direct.
        drive(1'b1, 1'b1, 2, 1'b1);
        tick();
        expect_out("nomacro", 1, 2, 3);
        drive(1'b1, 1'b1, 4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.in_data = ~bus.in_data;
            bus.sel     = SEL_W'(i + 5);
            tick();
        end
        load_default_data();
        expect_out("stall", 1, 2, 3);
        check("stall_drop", int'(bus.drop_cnt), 3);
        drive(1'b1, 1'b1, 4, 1'b1);
        tick();
        expect_out("release", 1, 4, 5);
        drive(1'b1, 1'b1, 7, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        expect_out("rst_mid", 0, 0, 0);
        check("rst_mid_drop", int'(bus.drop_cnt), 0);
        drive(1'b1, 1'b1, 0, 1'b1);
        tick();
        expect_out("post_rst", 1, 0, 1);
`endif

        // Saturation: 300 dropped requests.
        drive(1'b1, 1'b0, 1, 1'b1);
        tick();
        expect_out("sat_load", 1, 1, 2);
        drive(1'b1, 1'b0, 3, 1'b0);
        quiet = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        quiet = 1'b0;
        check("sat_drop", int'(bus.drop_cnt), 255);
        expect_out("sat_hold", 1, 1, 2);

        // Pop, then ready while empty has no effect.
        drive(1'b0, 1'b0, 3, 1'b1);
        tick();
        expect_out("pop", 0, 1, 2);
        tick();
        expect_out("idle_ready", 0, 1, 2);
        check("final_drop", int'(bus.drop_cnt), 255);

        @(negedge clk);
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
